l1_l2_arbiter: RTL



---
 rtl/l1_l2_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter between the split L1 I/D caches and the single-ported L2.
// One transaction is in flight at a time: IDLE -> GRANT (L2 strobe held) -> DONE (resp pulse).
module l1_l2_arbiter (
    input  logic         clk,
    input  logic         rst,

    input  logic         i_mem_read,
    input  logic [15:0]  i_mem_address,
    output logic         i_mem_resp,
    output logic [127:0] i_mem_rdata,

    input  logic         d_mem_read,
    input  logic         d_mem_write,
    input  logic [15:0]  d_mem_address,
    input  logic [127:0] d_mem_wdata,
    output logic         d_mem_resp,
    output logic [127:0] d_mem_rdata,

    output logic         l2_mem_read,
    output logic         l2_mem_write,
    output logic [15:0]  l2_mem_address,
    output logic [127:0] l2_mem_wdata,
    input  logic         l2_mem_resp,
    input  logic [127:0] l2_mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]   state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         owner_q, owner_d;
    logic         l2_read_q, l2_read_d;
    logic         l2_write_q, l2_write_d;
    logic [15:0]  addr_q, addr_d;
    logic [127:0] wdata_q, wdata_d;
    logic [127:0] rdata_q, rdata_d;
    logic         i_resp_q, i_resp_d;
    logic         d_resp_q, d_resp_d;

    logic         i_req_s;
    logic         d_req_s;
    logic         grant_d_s;

    // Both D strobes high is malformed and never counts as a request.
    assign i_req_s   = i_mem_read;
    assign d_req_s   = d_mem_read ^ d_mem_write;
    assign grant_d_s = d_req_s & (~i_req_s | (last_grant_q == OWN_I));

    // Next-state and datapath update for the three-state transaction FSM
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        l2_read_d    = l2_read_q;
        l2_write_d   = l2_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_s || d_req_s) begin
                    state_d = ST_GRANT;
                    owner_d = grant_d_s ? OWN_D : OWN_I;
                    if (grant_d_s) begin
                        l2_read_d  = d_mem_read;
                        l2_write_d = d_mem_write;
                        addr_d     = d_mem_address;
                        wdata_d    = d_mem_wdata;
                    end else begin
                        l2_read_d  = 1'b1;
                        l2_write_d = 1'b0;
                        addr_d     = i_mem_address;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (l2_mem_resp) begin
                    state_d      = ST_DONE;
                    rdata_d      = l2_mem_rdata;
                    last_grant_d = owner_q;
                    l2_read_d    = 1'b0;
                    l2_write_d   = 1'b0;
                    i_resp_d     = (owner_q == OWN_I);
                    d_resp_d     = (owner_q == OWN_D);
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                l2_read_d  = 1'b0;
                l2_write_d = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                l2_read_d  = 1'b0;
                l2_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= OWN_D;
            owner_q      <= OWN_I;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 128'h0;
            rdata_q      <= 128'h0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            l2_read_q    <= l2_read_d;
            l2_write_q   <= l2_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign l2_mem_read    = l2_read_q;
    assign l2_mem_write   = l2_write_q;
    assign l2_mem_address = addr_q;
    assign l2_mem_wdata   = wdata_q;
    assign i_mem_resp     = i_resp_q;
    assign d_mem_resp     = d_resp_q;
    assign i_mem_rdata    = rdata_q;
    assign d_mem_rdata    = rdata_q;

endmodule
